// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner for IF0: arbitrates next-PC sources, holds the PC across cache
// stalls while latching redirects, and emits front-end flush and stall-count.
module fetch_redirect_ctrl #(
    parameter int unsigned WORD     = 32,
    parameter logic [WORD-1:0] RESET_PC = WORD'(32'h1C000000),
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Pre_Branch,
    input  logic [WORD-1:0]  Pre_PC,
    input  logic             EX_Branch,
    input  logic [WORD-1:0]  EX_PC,
    input  logic             Exc_Valid,
    input  logic [WORD-1:0]  Exc_PC,
    input  logic             PC_stall_from_ICache,
    input  logic             PC_stall_from_DCache,
    output logic [WORD-1:0]  PC_out,
    output logic             Flush_front,
    output logic             Redirect_pending,
    output logic [CNT_W-1:0] Stall_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Ordered so that a numerically larger kind has higher priority.
    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_PRE  = 2'd1,
        K_EX   = 2'd2,
        K_EXC  = 2'd3
    } kind_t;

    state_t          state;
    kind_t           pend_kind;
    logic [WORD-1:0] pend_tgt;

    logic            stall;
    kind_t           in_kind;
    logic [WORD-1:0] in_tgt;
    logic            hold_take;
    logic            flush_next;
    logic [WORD-1:0] pc_next;
    kind_t           pend_kind_next;
    logic [WORD-1:0] pend_tgt_next;

    assign stall = PC_stall_from_ICache | PC_stall_from_DCache;

    // Highest-priority live request this cycle.
    always_comb begin
        in_kind = K_NONE;
        in_tgt  = Pre_PC;
        if (Exc_Valid) begin
            in_kind = K_EXC;
            in_tgt  = Exc_PC;
        end else if (EX_Branch) begin
            in_kind = K_EX;
            in_tgt  = EX_PC;
        end else if (Pre_Branch) begin
            in_kind = K_PRE;
            in_tgt  = Pre_PC;
        end
    end

    // Next PC, next pending entry and flush decision for this cycle.
    always_comb begin
        pc_next        = PC_out;
        pend_kind_next = pend_kind;
        pend_tgt_next  = pend_tgt;
        hold_take      = (in_kind != K_NONE) && (in_kind >= pend_kind);
        if (stall) begin
            // PC frozen; latch a request only if it is at least as strong as what is waiting.
            if (hold_take) begin
                pend_kind_next = in_kind;
                pend_tgt_next  = in_tgt;
            end
        end else begin
            // Pending is always consumed or overridden once the stall is gone.
            pend_kind_next = K_NONE;
            if (Exc_Valid || EX_Branch) begin
                pc_next = in_tgt;
            end else if (pend_kind != K_NONE) begin
                pc_next = pend_tgt;
            end else if (Pre_Branch) begin
                pc_next = Pre_PC;
            end else begin
                pc_next = PC_out + WORD'(4);
            end
        end
        flush_next = ((in_kind == K_EXC) || (in_kind == K_EX)) && (!stall || hold_take);
    end

    // State register, PC, pending redirect, flush pulse and stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= RUN;
            PC_out           <= RESET_PC;
            pend_kind        <= K_NONE;
            pend_tgt         <= '0;
            Flush_front      <= 1'b0;
            Redirect_pending <= 1'b0;
            Stall_cnt        <= '0;
        end else begin
            case (state)
                RUN:     if (stall)  state <= HOLD;
                HOLD:    if (!stall) state <= RUN;
                default: state <= RUN;
            endcase
            PC_out           <= pc_next;
            pend_kind        <= pend_kind_next;
            pend_tgt         <= pend_tgt_next;
            Flush_front      <= flush_next;
            Redirect_pending <= (pend_kind_next != K_NONE);
            Stall_cnt        <= Stall_cnt + CNT_W'(stall);
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: each scenario queues one expected
// output tuple per driven cycle and compares it after the following edge.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        Pre_Branch;
    logic [31:0] Pre_PC;
    logic        EX_Branch;
    logic [31:0] EX_PC;
    logic        Exc_Valid;
    logic [31:0] Exc_PC;
    logic        PC_stall_from_ICache;
    logic        PC_stall_from_DCache;
    logic [31:0] PC_out;
    logic        Flush_front;
    logic        Redirect_pending;
    logic [31:0] Stall_cnt;

    fetch_redirect_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .Pre_Branch           (Pre_Branch),
        .Pre_PC               (Pre_PC),
        .EX_Branch            (EX_Branch),
        .EX_PC                (EX_PC),
        .Exc_Valid            (Exc_Valid),
        .Exc_PC               (Exc_PC),
        .PC_stall_from_ICache (PC_stall_from_ICache),
        .PC_stall_from_DCache (PC_stall_from_DCache),
        .PC_out               (PC_out),
        .Flush_front          (Flush_front),
        .Redirect_pending     (Redirect_pending),
        .Stall_cnt            (Stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        fl;
        logic        pd;
        logic [31:0] cnt;
    } exp_t;

    // req bits: [2] Exc_Valid, [1] EX_Branch, [0] Pre_Branch
    typedef struct packed {
        logic        rst_n;
        logic        ic;
        logic        dc;
        logic [2:0]  req;
        logic [31:0] pre_pc;
        logic [31:0] ex_pc;
        logic [31:0] exc_pc;
        exp_t        e;
    } step_t;

    localparam logic [31:0] Z = 32'h0;

    step_t stim[$];
    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic step_t mk(input logic rst_n, input logic ic, input logic dc,
                                 input logic [2:0] req, input logic [31:0] pre_pc,
                                 input logic [31:0] ex_pc, input logic [31:0] exc_pc,
                                 input logic [31:0] e_pc, input logic e_fl,
                                 input logic e_pd, input logic [31:0] e_cnt);
        step_t s;
        s.rst_n  = rst_n;
        s.ic     = ic;
        s.dc     = dc;
        s.req    = req;
        s.pre_pc = pre_pc;
        s.ex_pc  = ex_pc;
        s.exc_pc = exc_pc;
        s.e.pc   = e_pc;
        s.e.fl   = e_fl;
        s.e.pd   = e_pd;
        s.e.cnt  = e_cnt;
        return s;
    endfunction

    task automatic drive(input step_t s);
        rst                  = s.rst_n;
        PC_stall_from_ICache = s.ic;
        PC_stall_from_DCache = s.dc;
        Exc_Valid            = s.req[2];
        EX_Branch            = s.req[1];
        Pre_Branch           = s.req[0];
        Pre_PC               = s.pre_pc;
        EX_PC                = s.ex_pc;
        Exc_PC               = s.exc_pc;
    endtask

    task automatic do_reset();
        drive(mk(1'b0, 1'b0, 1'b0, 3'b000, Z, Z, Z, Z, 1'b0, 1'b0, Z));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        stim.delete();
        stim.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000000, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b0, 1'b1, 1'b0, 3'b010, Z, 32'h1C000040, Z, 32'h1C000000, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000004, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000008, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C00000C, 1'b0, 1'b0, 32'd0));
        foreach (stim[i]) begin
            drive(stim[i]);
            sb.push_back(stim[i].e);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {PC_out, Flush_front, Redirect_pending, Stall_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset[%0d] got pc=%h fl=%b pd=%b cnt=%0d want pc=%h fl=%b pd=%b cnt=%0d",
                         i, got.pc, got.fl, got.pd, got.cnt, e.pc, e.fl, e.pd, e.cnt);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e, got;
        do_reset();
        stim.delete();
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000004, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000008, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C00000C, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000010, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b111, 32'h1C000300, 32'h1C000200, 32'h1C008000,
                          32'h1C008000, 1'b1, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C008004, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b011, 32'h1C000300, 32'h1C000200, Z,
                          32'h1C000200, 1'b1, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000204, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b001, 32'h1C000300, Z, Z, 32'h1C000300, 1'b0, 1'b0, 32'd0));
        foreach (stim[i]) begin
            drive(stim[i]);
            sb.push_back(stim[i].e);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {PC_out, Flush_front, Redirect_pending, Stall_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL priority[%0d] got pc=%h fl=%b pd=%b cnt=%0d want pc=%h fl=%b pd=%b cnt=%0d",
                         i, got.pc, got.fl, got.pd, got.cnt, e.pc, e.fl, e.pd, e.cnt);
            end
        end
    endtask

    task automatic test_latch_stall();
        exp_t e, got;
        do_reset();
        stim.delete();
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b000, Z, Z, Z, 32'h1C000000, 1'b0, 1'b0, 32'd1));
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, Z, 32'h1C000400, Z, 32'h1C000000, 1'b1, 1'b1, 32'd2));
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b000, Z, Z, Z, 32'h1C000000, 1'b0, 1'b1, 32'd3));
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b000, Z, Z, Z, 32'h1C000000, 1'b0, 1'b1, 32'd4));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000400, 1'b0, 1'b0, 32'd4));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000404, 1'b0, 1'b0, 32'd4));
        foreach (stim[i]) begin
            drive(stim[i]);
            sb.push_back(stim[i].e);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {PC_out, Flush_front, Redirect_pending, Stall_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL latch_stall[%0d] got pc=%h fl=%b pd=%b cnt=%0d want pc=%h fl=%b pd=%b cnt=%0d",
                         i, got.pc, got.fl, got.pd, got.cnt, e.pc, e.fl, e.pd, e.cnt);
            end
        end
    endtask

    task automatic test_override();
        exp_t e, got;
        do_reset();
        stim.delete();
        stim.push_back(mk(1'b1, 1'b0, 1'b1, 3'b001, 32'h1C000500, Z, Z, 32'h1C000000, 1'b0, 1'b1, 32'd1));
        stim.push_back(mk(1'b1, 1'b0, 1'b1, 3'b010, Z, 32'h1C000600, Z, 32'h1C000000, 1'b1, 1'b1, 32'd2));
        stim.push_back(mk(1'b1, 1'b0, 1'b1, 3'b001, 32'h1C000700, Z, Z, 32'h1C000000, 1'b0, 1'b1, 32'd3));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000600, 1'b0, 1'b0, 32'd3));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000604, 1'b0, 1'b0, 32'd3));
        foreach (stim[i]) begin
            drive(stim[i]);
            sb.push_back(stim[i].e);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {PC_out, Flush_front, Redirect_pending, Stall_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL override[%0d] got pc=%h fl=%b pd=%b cnt=%0d want pc=%h fl=%b pd=%b cnt=%0d",
                         i, got.pc, got.fl, got.pd, got.cnt, e.pc, e.fl, e.pd, e.cnt);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e, got;
        do_reset();
        stim.delete();
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b100, Z, Z, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h00000000, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h00000004, 1'b0, 1'b0, 32'd0));
        foreach (stim[i]) begin
            drive(stim[i]);
            sb.push_back(stim[i].e);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {PC_out, Flush_front, Redirect_pending, Stall_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL wrap[%0d] got pc=%h fl=%b pd=%b cnt=%0d want pc=%h fl=%b pd=%b cnt=%0d",
                         i, got.pc, got.fl, got.pd, got.cnt, e.pc, e.fl, e.pd, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e, got;
        do_reset();
        stim.delete();
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, Z, 32'h1C000900, Z, 32'h1C000000, 1'b1, 1'b1, 32'd1));
        stim.push_back(mk(1'b0, 1'b1, 1'b0, 3'b000, Z, Z, Z, 32'h1C000000, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b000, Z, Z, Z, 32'h1C000000, 1'b0, 1'b0, 32'd1));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000004, 1'b0, 1'b0, 32'd1));
        foreach (stim[i]) begin
            drive(stim[i]);
            sb.push_back(stim[i].e);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {PC_out, Flush_front, Redirect_pending, Stall_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_mid_stall[%0d] got pc=%h fl=%b pd=%b cnt=%0d want pc=%h fl=%b pd=%b cnt=%0d",
                         i, got.pc, got.fl, got.pd, got.cnt, e.pc, e.fl, e.pd, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        do_reset();
        stim.delete();
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b010, Z, 32'h1C000100, Z, 32'h1C000100, 1'b1, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b010, Z, 32'h1C000200, Z, 32'h1C000200, 1'b1, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b001, 32'h1C000300, Z, Z, 32'h1C000300, 1'b0, 1'b0, 32'd0));
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, Z, 32'h1C000A00, Z, 32'h1C000300, 1'b1, 1'b1, 32'd1));
        stim.push_back(mk(1'b1, 1'b0, 1'b1, 3'b010, Z, 32'h1C000B00, Z, 32'h1C000300, 1'b1, 1'b1, 32'd2));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000B00, 1'b0, 1'b0, 32'd2));
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b100, Z, Z, 32'h1C000C00, 32'h1C000B00, 1'b1, 1'b1, 32'd3));
        stim.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, Z, 32'h1C000D00, Z, 32'h1C000B00, 1'b0, 1'b1, 32'd4));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C000C00, 1'b0, 1'b0, 32'd4));
        stim.push_back(mk(1'b1, 1'b1, 1'b1, 3'b001, 32'h1C000E00, Z, Z, 32'h1C000C00, 1'b0, 1'b1, 32'd5));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b001, 32'h1C000F00, Z, Z, 32'h1C000E00, 1'b0, 1'b0, 32'd5));
        stim.push_back(mk(1'b1, 1'b0, 1'b1, 3'b001, 32'h1C001000, Z, Z, 32'h1C000E00, 1'b0, 1'b1, 32'd6));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b010, Z, 32'h1C001100, Z, 32'h1C001100, 1'b1, 1'b0, 32'd6));
        stim.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, Z, Z, Z, 32'h1C001104, 1'b0, 1'b0, 32'd6));
        foreach (stim[i]) begin
            drive(stim[i]);
            sb.push_back(stim[i].e);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {PC_out, Flush_front, Redirect_pending, Stall_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d] got pc=%h fl=%b pd=%b cnt=%0d want pc=%h fl=%b pd=%b cnt=%0d",
                         i, got.pc, got.fl, got.pd, got.cnt, e.pc, e.fl, e.pd, e.cnt);
            end
        end
    endtask

    initial begin
        drive(mk(1'b0, 1'b0, 1'b0, 3'b000, Z, Z, Z, Z, 1'b0, 1'b0, Z));
        #1;
        test_reset();
        test_priority();
        test_latch_stall();
        test_override();
        test_wrap();
        test_reset_mid_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
